usb_rx_ctrl: RTL and testbench

//  Receive control unit for the USB full-speed RX path. Sequences the 8-bit RX shift register: counts its

---
 rtl/usb_rx_pkg.sv | 22 ++
 rtl/flex_counter.sv | 41 ++++
 rtl/usb_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB full-speed RX control path.
// Holds the controller state encoding and default packet framing constants.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC_WAIT,
        S_SYNC_CHK,
        S_RCV,
        S_WRITE,
        S_EOP_WAIT,
        S_DONE,
        S_ERR_WAIT,
        S_ERR_EOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF     = 8'h80;
    localparam int         MAX_PKT_BYTES_DEF = 64;
    localparam int         BIT_CNT_W         = 3;
    localparam int         CNT_W             = 4;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: counts 0..rollover_val-1 on count_enable and wraps to 0.
// rollover_flag marks the enabled cycle in which the wrap happens.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    assign rollover_flag = count_enable & ~clear
                         & (count_q == (rollover_val - NUM_CNT_BITS'(1)));
    assign count_out     = count_q;

    // next count: clear wins, then wrap or increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_q + NUM_CNT_BITS'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: frames RX shift-register bytes, checks SYNC and EOP alignment,
// and strobes completed data bytes into the RX FIFO.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int         MAX_PKT_BYTES = MAX_PKT_BYTES_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic [7:0] rx_data,
    input  logic       fifo_full,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic       packet_done,
    output logic [6:0] byte_count
);

    localparam logic [6:0]       MAX_BC  = 7'(MAX_PKT_BYTES);
    localparam logic [CNT_W-1:0] BIT_ROLL = CNT_W'(1 << BIT_CNT_W);

    rx_state_t        state_q, state_d;
    logic             rcving_q, rcving_d;
    logic             w_enable_q, w_enable_d;
    logic             r_error_q, r_error_d;
    logic             packet_done_q, packet_done_d;
    logic [6:0]       byte_count_q, byte_count_d;

    logic [CNT_W-1:0] bit_cnt;
    logic             byte_complete;
    logic             cnt_clear;
    logic             cnt_en;
    logic             counting;

    // bits are only counted while framing; eop discards any in-flight bit
    assign counting  = (state_q == S_SYNC_WAIT) | (state_q == S_SYNC_CHK)
                     | (state_q == S_RCV) | (state_q == S_WRITE);
    assign cnt_en    = shift_enable & ~eop & counting;
    assign cnt_clear = ((state_q == S_IDLE) & d_edge)
                     | ((state_q != S_IDLE) & eop);

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (BIT_ROLL),
        .count_out     (bit_cnt),
        .rollover_flag (byte_complete)
    );

    // next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        rcving_d      = rcving_q;
        w_enable_d    = 1'b0;
        r_error_d     = r_error_q;
        packet_done_d = 1'b0;
        byte_count_d  = byte_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (d_edge) begin
                    state_d      = S_SYNC_WAIT;
                    byte_count_d = '0;
                    r_error_d    = 1'b0;
                    rcving_d     = 1'b1;
                end
            end
            S_SYNC_WAIT: begin
                if (eop) begin
                    state_d   = S_ERR_EOP;
                    r_error_d = 1'b1;
                end else if (byte_complete) begin
                    state_d = S_SYNC_CHK;
                end
            end
            S_SYNC_CHK: begin
                if (rx_data == SYNC_BYTE) begin
                    state_d = S_RCV;
                end else begin
                    state_d   = S_ERR_WAIT;
                    r_error_d = 1'b1;
                end
            end
            S_RCV: begin
                if (eop) begin
                    if (bit_cnt == '0) begin
                        state_d = S_EOP_WAIT;
                    end else begin
                        state_d   = S_ERR_EOP;
                        r_error_d = 1'b1;
                    end
                end else if (byte_complete) begin
                    // write decision is registered so w_enable has no input path
                    state_d    = S_WRITE;
                    w_enable_d = ~fifo_full & (byte_count_q != MAX_BC);
                end
            end
            S_WRITE: begin
                if (w_enable_q) begin
                    state_d      = S_RCV;
                    byte_count_d = byte_count_q + 7'd1;
                end else begin
                    state_d   = S_ERR_WAIT;
                    r_error_d = 1'b1;
                end
            end
            S_EOP_WAIT: begin
                if (!eop) begin
                    state_d       = S_DONE;
                    packet_done_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rcving_d = 1'b0;
            end
            S_ERR_WAIT: begin
                if (eop) begin
                    state_d   = S_ERR_EOP;
                    r_error_d = 1'b1;
                end
            end
            S_ERR_EOP: begin
                r_error_d = 1'b1;
                if (!eop) begin
                    state_d  = S_IDLE;
                    rcving_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rcving_d = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            rcving_q      <= 1'b0;
            w_enable_q    <= 1'b0;
            r_error_q     <= 1'b0;
            packet_done_q <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            rcving_q      <= rcving_d;
            w_enable_q    <= w_enable_d;
            r_error_q     <= r_error_d;
            packet_done_q <= packet_done_d;
            byte_count_q  <= byte_count_d;
        end
    end

    assign rcving      = rcving_q;
    assign w_enable    = w_enable_q;
    assign r_error     = r_error_q;
    assign packet_done = packet_done_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed packet table plus hand sequences for
// max-length overflow, write/done latency and mid-packet reset.
module tb_usb_rx_ctrl;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rx_data;
    logic       fifo_full;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic       packet_done;
    logic [6:0] byte_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq[$];
    int         dcount = 0;

    usb_rx_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .rx_data      (rx_data),
        .fifo_full    (fifo_full),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .packet_done  (packet_done),
        .byte_count   (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every FIFO write and completion pulse
    always @(posedge clk) begin
        if (w_enable) wq.push_back(rx_data);
        if (packet_done) dcount = dcount + 1;
    end

    typedef struct {
        logic [7:0]  sync;
        int          nbytes;
        logic [15:0] data;
        int          tail;
        int          full_idx;
        int          exp_wr;
        logic        exp_err;
        int          exp_done;
        logic [6:0]  exp_bc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        shift_enable = 1'b1;
        rx_data      = {b, rx_data[7:1]};
        tick();
        shift_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic end_pkt();
        eop = 1'b1;
        repeat (6) tick();
        eop = 1'b0;
        tick();
    endtask

    initial begin
        int         wbase;
        int         dbase;
        logic [15:0] d;
        logic [7:0] b;

        tbl[0] = '{8'h80, 2, 16'h3CA5, 0, -1, 2, 1'b0, 1, 7'd2};
        tbl[1] = '{8'h81, 1, 16'h0011, 0, -1, 0, 1'b1, 0, 7'd0};
        tbl[2] = '{8'h80, 0, 16'h0000, 0, -1, 0, 1'b0, 1, 7'd0};
        tbl[3] = '{8'h80, 1, 16'h005A, 3, -1, 1, 1'b1, 0, 7'd1};
        tbl[4] = '{8'h80, 2, 16'h3412, 0, 1, 1, 1'b1, 0, 7'd1};
        tbl[5] = '{8'h40, 0, 16'h0000, 0, -1, 0, 1'b1, 0, 7'd0};
        tbl[6] = '{8'h80, 1, 16'h00FF, 0, -1, 1, 1'b0, 1, 7'd1};

        n_rst        = 1'b0;
        d_edge       = 1'b0;
        eop          = 1'b0;
        shift_enable = 1'b0;
        rx_data      = 8'h00;
        fifo_full    = 1'b0;
        #12;
        chk("rst_rcving", 32'(rcving), 0);
        chk("rst_wen", 32'(w_enable), 0);
        chk("rst_err", 32'(r_error), 0);
        chk("rst_done", 32'(packet_done), 0);
        chk("rst_bc", 32'(byte_count), 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) begin
            wbase = wq.size();
            dbase = dcount;
            d     = tbl[k].data;
            start_pkt();
            chk($sformatf("v%0d_start_rcving", k), 32'(rcving), 1);
            chk($sformatf("v%0d_start_err", k), 32'(r_error), 0);
            send_byte(tbl[k].sync);
            for (int i = 0; i < tbl[k].nbytes; i++) begin
                b = d[8*i +: 8];
                fifo_full = (i == tbl[k].full_idx);
                send_byte(b);
                fifo_full = 1'b0;
            end
            for (int i = 0; i < tbl[k].tail; i++) send_bit(1'b1);
            chk($sformatf("v%0d_pre_eop_rcving", k), 32'(rcving), 1);
            end_pkt();
            repeat (3) tick();
            chk($sformatf("v%0d_writes", k), 32'(wq.size() - wbase),
                32'(tbl[k].exp_wr));
            if (wq.size() - wbase == tbl[k].exp_wr) begin
                for (int i = 0; i < tbl[k].exp_wr; i++) begin
                    b = d[8*i +: 8];
                    chk($sformatf("v%0d_wdata%0d", k, i),
                        32'(wq[wbase+i]), 32'(b));
                end
            end
            chk($sformatf("v%0d_err", k), 32'(r_error), 32'(tbl[k].exp_err));
            chk($sformatf("v%0d_done", k), 32'(dcount - dbase),
                32'(tbl[k].exp_done));
            chk($sformatf("v%0d_bc", k), 32'(byte_count), 32'(tbl[k].exp_bc));
            chk($sformatf("v%0d_idle_rcving", k), 32'(rcving), 0);
        end

        // 65 data bytes against a 64-byte limit
        wbase = wq.size();
        dbase = dcount;
        start_pkt();
        send_byte(8'h80);
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        chk("max_bc64", 32'(byte_count), 64);
        chk("max_err_before", 32'(r_error), 0);
        send_byte(8'hEE);
        chk("max_err_after", 32'(r_error), 1);
        chk("max_rcving_errwait", 32'(rcving), 1);
        end_pkt();
        repeat (3) tick();
        chk("max_writes", 32'(wq.size() - wbase), 64);
        chk("max_last_byte", 32'(wq[wq.size()-1]), 32'h3F);
        chk("max_bc_final", 32'(byte_count), 64);
        chk("max_err_final", 32'(r_error), 1);
        chk("max_done", 32'(dcount - dbase), 0);
        chk("max_rcving_final", 32'(rcving), 0);

        // write latency, then reset in the middle of a byte
        start_pkt();
        send_byte(8'h80);
        b = 8'h77;
        for (int i = 0; i < 7; i++) send_bit(b[i]);
        shift_enable = 1'b1;
        rx_data      = {b[7], rx_data[7:1]};
        tick();
        shift_enable = 1'b0;
        chk("lat_wen_n1", 32'(w_enable), 1);
        chk("lat_wdata", 32'(rx_data), 32'h77);
        tick();
        chk("lat_wen_n2", 32'(w_enable), 0);
        chk("lat_bc", 32'(byte_count), 1);
        tick();
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_rcving", 32'(rcving), 0);
        chk("arst_wen", 32'(w_enable), 0);
        chk("arst_err", 32'(r_error), 0);
        chk("arst_done", 32'(packet_done), 0);
        chk("arst_bc", 32'(byte_count), 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        wbase = wq.size();
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        eop = 1'b1;
        repeat (6) tick();
        eop = 1'b0;
        chk("post_rst_done_m", 32'(packet_done), 0);
        tick();
        chk("post_rst_done_m1", 32'(packet_done), 1);
        chk("post_rst_rcving_done", 32'(rcving), 1);
        tick();
        chk("post_rst_done_m2", 32'(packet_done), 0);
        chk("post_rst_rcving", 32'(rcving), 0);
        chk("post_rst_writes", 32'(wq.size() - wbase), 1);
        if (wq.size() > wbase) chk("post_rst_wdata", 32'(wq[wbase]), 32'hC3);
        chk("post_rst_bc", 32'(byte_count), 1);
        chk("post_rst_err", 32'(r_error), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
